sonic_rp_vc_ast_mux: RTL and testbench

//  Parametrised multi-VC Avalon-ST mux/demux for the root-port sim model. Sits between NUM_VC
//  BFM VC interface instances and the single RP rx_st/tx_st link. Packet-atomic round-robin TX

---
 rtl/sonic_rp_pkg.sv | 30 +++
 rtl/sonic_rp_rr_arb.sv | 33 +++
 rtl/sonic_rp_vc_ast_mux.sv | 202 ++++++++++++++++++++
 tb/tb_sonic_rp_vc_ast_mux.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_rp_pkg.sv
// Shared types, constants and helpers for the root-port multi-VC Avalon-ST mux.
package sonic_rp_pkg;

    // Traffic-class field position inside header DW0 of the first beat
    localparam int unsigned TC_LSB = 20;
    localparam int unsigned TC_MSB = 22;

    typedef enum logic {TX_IDLE, TX_LOCK} tx_state_e;

    function automatic bit data_w_legal(input int unsigned w);
        return (w == 64) || (w == 128) || (w == 256);
    endfunction

    // Empty field width, never narrower than one bit
    function automatic int unsigned empty_w(input int unsigned w);
        int unsigned e;
        e = $clog2(w / 64);
        return (e < 1) ? 1 : e;
    endfunction

    // Index width for a set of n ports, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned tc_to_vc(input logic [2:0] tc, input int unsigned num_vc);
        return 32'(tc) % num_vc;
    endfunction

endpackage

// File: rtl/sonic_rp_rr_arb.sv
// Round-robin requester picker: first request at or after ptr wins, wrapping mod NUM_VC.
module sonic_rp_rr_arb
    import sonic_rp_pkg::*;
#(
    parameter int unsigned NUM_VC = 2
) (
    input  logic [NUM_VC-1:0]         req,
    input  logic [idx_w(NUM_VC)-1:0]  ptr,
    output logic [NUM_VC-1:0]         grant,
    output logic [idx_w(NUM_VC)-1:0]  grant_idx,
    output logic                      grant_any
);
    localparam int unsigned VC_W = idx_w(NUM_VC);

    // Scan requesters starting from ptr and take the first one found
    always_comb begin
        logic [VC_W-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (32'(ptr) + i >= NUM_VC) idx = VC_W'(32'(ptr) + i - NUM_VC);
            else                        idx = VC_W'(32'(ptr) + i);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sonic_rp_vc_ast_mux.sv
// Multi-VC Avalon-ST mux/demux between VC BFM ports and the single RP rx_st/tx_st link.
// TX: packet-atomic round-robin; RX: steering by header TC; delayed internal reset.
// Optional statistics/protocol-error ports are built when SONIC_RP_VC_STATS_EN is defined.
module sonic_rp_vc_ast_mux
    import sonic_rp_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned RST_STAGES = 2,
    parameter int unsigned EMPTY_W    = empty_w(DATA_W)
) (
    input  logic                      pld_clk,
    input  logic                      rstn,
    output logic                      vc_rstn,
    input  logic [NUM_VC-1:0]         tx_vc_valid,
    input  logic [NUM_VC-1:0]         tx_vc_sop,
    input  logic [NUM_VC-1:0]         tx_vc_eop,
    input  logic [NUM_VC*EMPTY_W-1:0] tx_vc_empty,
    input  logic [NUM_VC*DATA_W-1:0]  tx_vc_data,
    output logic [NUM_VC-1:0]         tx_vc_ready,
    output logic                      tx_st_valid,
    output logic                      tx_st_sop,
    output logic                      tx_st_eop,
    output logic [EMPTY_W-1:0]        tx_st_empty,
    output logic [DATA_W-1:0]         tx_st_data,
    input  logic                      tx_st_ready,
    input  logic                      rx_st_valid,
    input  logic                      rx_st_sop,
    input  logic                      rx_st_eop,
    input  logic [EMPTY_W-1:0]        rx_st_empty,
    input  logic [DATA_W-1:0]         rx_st_data,
    output logic                      rx_st_ready,
    output logic [NUM_VC-1:0]         rx_vc_valid,
    output logic                      rx_vc_sop,
    output logic                      rx_vc_eop,
    output logic [EMPTY_W-1:0]        rx_vc_empty,
    output logic [DATA_W-1:0]         rx_vc_data,
    input  logic [NUM_VC-1:0]         rx_vc_ready
`ifdef SONIC_RP_VC_STATS_EN
    ,
    output logic [NUM_VC*32-1:0]      stat_tx_pkt,
    output logic [NUM_VC*32-1:0]      stat_rx_pkt,
    output logic                      stat_proto_err
`endif
);
    localparam int unsigned     VC_W    = idx_w(NUM_VC);
    localparam logic [VC_W-1:0] LAST_VC = VC_W'(NUM_VC - 1);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("sonic_rp_vc_ast_mux: DATA_W must be 64, 128 or 256");
    end

    function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
        return (v == LAST_VC) ? '0 : v + 1'b1;
    endfunction

    // Reset release delay: ones shift toward vc_rstn after rstn rises
    logic [RST_STAGES-1:0] rst_pipe_q;
    always_ff @(posedge pld_clk or negedge rstn) begin
        if (!rstn) rst_pipe_q <= '0;
        else       rst_pipe_q <= RST_STAGES'({rst_pipe_q, 1'b1});
    end
    assign vc_rstn = rst_pipe_q[RST_STAGES-1];

    // ---------------- TX arbitration ----------------
    tx_state_e         state_q, state_d;
    logic [VC_W-1:0]   lock_q, lock_d, ptr_q, ptr_d;
    logic [NUM_VC-1:0] arb_grant;
    logic [VC_W-1:0]   arb_idx, tx_sel;
    logic              arb_any, tx_acc;

    sonic_rp_rr_arb #(
        .NUM_VC (NUM_VC)
    ) u_arb (
        .req       (tx_vc_valid & tx_vc_sop),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Route the granted (IDLE) or locked (LOCK) VC straight onto the link
    always_comb begin
        tx_sel      = (state_q == TX_LOCK) ? lock_q : arb_idx;
        tx_st_valid = vc_rstn & ((state_q == TX_LOCK) ? tx_vc_valid[lock_q] : arb_any);
        tx_st_sop   = tx_vc_sop[tx_sel];
        tx_st_eop   = tx_vc_eop[tx_sel];
        tx_st_empty = tx_vc_empty[tx_sel*EMPTY_W +: EMPTY_W];
        tx_st_data  = tx_vc_data[tx_sel*DATA_W +: DATA_W];
        tx_vc_ready = '0;
        if (vc_rstn) begin
            if (state_q == TX_LOCK) tx_vc_ready[lock_q] = tx_st_ready;
            else                    tx_vc_ready = arb_grant & {NUM_VC{tx_st_ready}};
        end
    end

    assign tx_acc = tx_st_valid & tx_st_ready;

    // Lock onto a VC for a multi-beat packet; advance the pointer past it on eop
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        case (state_q)
            TX_IDLE: begin
                if (tx_acc) begin
                    lock_d = arb_idx;
                    if (tx_st_eop) ptr_d   = next_vc(arb_idx);
                    else           state_d = TX_LOCK;
                end
            end
            TX_LOCK: begin
                if (tx_acc && tx_st_eop) begin
                    state_d = TX_IDLE;
                    ptr_d   = next_vc(lock_q);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // TX state register, held cleared until the delayed reset releases
    always_ff @(posedge pld_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= TX_IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
        end else if (!vc_rstn) begin
            state_q <= TX_IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---------------- RX steering ----------------
    logic [VC_W-1:0] rx_vc_q, rx_sel;
    logic            rx_acc;

    // A sop beat is steered by its own TC; later beats follow the latched VC
    always_comb begin
        rx_sel = (rx_st_valid && rx_st_sop) ?
                 VC_W'(tc_to_vc(rx_st_data[TC_MSB:TC_LSB], NUM_VC)) : rx_vc_q;
        rx_vc_valid         = '0;
        rx_vc_valid[rx_sel] = rx_st_valid & vc_rstn;
        rx_st_ready         = rx_vc_ready[rx_sel] & vc_rstn;
    end

    assign rx_acc      = rx_st_valid & rx_st_ready;
    assign rx_vc_sop   = rx_st_sop;
    assign rx_vc_eop   = rx_st_eop;
    assign rx_vc_empty = rx_st_empty;
    assign rx_vc_data  = rx_st_data;

    // Latch the destination VC when the sop beat is accepted
    always_ff @(posedge pld_clk or negedge rstn) begin
        if (!rstn)                   rx_vc_q <= '0;
        else if (!vc_rstn)           rx_vc_q <= '0;
        else if (rx_acc && rx_st_sop) rx_vc_q <= rx_sel;
    end

`ifdef SONIC_RP_VC_STATS_EN
    logic proto_err_q, proto_err_d;

    // Sticky: stray beat without sop while idle, or a new sop inside a locked packet
    always_comb begin
        proto_err_d = proto_err_q
                    | ((state_q == TX_IDLE) && (|(tx_vc_valid & ~tx_vc_sop)))
                    | ((state_q == TX_LOCK) && tx_vc_valid[lock_q] && tx_vc_sop[lock_q]);
    end

    // Protocol error flag register
    always_ff @(posedge pld_clk or negedge rstn) begin
        if (!rstn)         proto_err_q <= 1'b0;
        else if (!vc_rstn) proto_err_q <= 1'b0;
        else               proto_err_q <= proto_err_d;
    end
    assign stat_proto_err = proto_err_q;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_stats
        logic [31:0] tx_cnt_q, rx_cnt_q;
        // Saturating per-VC packet counters, bumped on accepted eop
        always_ff @(posedge pld_clk or negedge rstn) begin
            if (!rstn || !vc_rstn) begin
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (tx_acc && tx_st_eop && tx_sel == VC_W'(g) && tx_cnt_q != '1)
                    tx_cnt_q <= tx_cnt_q + 32'd1;
                if (rx_acc && rx_st_eop && rx_sel == VC_W'(g) && rx_cnt_q != '1)
                    rx_cnt_q <= rx_cnt_q + 32'd1;
            end
        end
        assign stat_tx_pkt[g*32 +: 32] = tx_cnt_q;
        assign stat_rx_pkt[g*32 +: 32] = rx_cnt_q;
    end
`endif

endmodule

// File: tb/tb_sonic_rp_vc_ast_mux.sv
// Directed, table-driven bench for sonic_rp_vc_ast_mux (DATA_W=128, NUM_VC=2, RST_STAGES=2).
module tb_sonic_rp_vc_ast_mux;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned NUM_VC  = 2;
    localparam int unsigned EMPTY_W = 1;
    localparam int unsigned NV      = 21;

    logic                      pld_clk = 1'b0;
    logic                      rstn    = 1'b0;
    logic                      vc_rstn;
    logic [NUM_VC-1:0]         tx_vc_valid, tx_vc_sop, tx_vc_eop, tx_vc_ready;
    logic [NUM_VC*EMPTY_W-1:0] tx_vc_empty;
    logic [NUM_VC*DATA_W-1:0]  tx_vc_data;
    logic                      tx_st_valid, tx_st_sop, tx_st_eop, tx_st_ready;
    logic [EMPTY_W-1:0]        tx_st_empty;
    logic [DATA_W-1:0]         tx_st_data;
    logic                      rx_st_valid, rx_st_sop, rx_st_eop, rx_st_ready;
    logic [EMPTY_W-1:0]        rx_st_empty;
    logic [DATA_W-1:0]         rx_st_data;
    logic [NUM_VC-1:0]         rx_vc_valid, rx_vc_ready;
    logic                      rx_vc_sop, rx_vc_eop;
    logic [EMPTY_W-1:0]        rx_vc_empty;
    logic [DATA_W-1:0]         rx_vc_data;
`ifdef SONIC_RP_VC_STATS_EN
    logic [NUM_VC*32-1:0]      stat_tx_pkt, stat_rx_pkt;
    logic                      stat_proto_err;
`endif

    always #5 pld_clk = ~pld_clk;

    sonic_rp_vc_ast_mux #(
        .DATA_W     (DATA_W),
        .NUM_VC     (NUM_VC),
        .RST_STAGES (2)
    ) dut (
        .pld_clk     (pld_clk),
        .rstn        (rstn),
        .vc_rstn     (vc_rstn),
        .tx_vc_valid (tx_vc_valid),
        .tx_vc_sop   (tx_vc_sop),
        .tx_vc_eop   (tx_vc_eop),
        .tx_vc_empty (tx_vc_empty),
        .tx_vc_data  (tx_vc_data),
        .tx_vc_ready (tx_vc_ready),
        .tx_st_valid (tx_st_valid),
        .tx_st_sop   (tx_st_sop),
        .tx_st_eop   (tx_st_eop),
        .tx_st_empty (tx_st_empty),
        .tx_st_data  (tx_st_data),
        .tx_st_ready (tx_st_ready),
        .rx_st_valid (rx_st_valid),
        .rx_st_sop   (rx_st_sop),
        .rx_st_eop   (rx_st_eop),
        .rx_st_empty (rx_st_empty),
        .rx_st_data  (rx_st_data),
        .rx_st_ready (rx_st_ready),
        .rx_vc_valid (rx_vc_valid),
        .rx_vc_sop   (rx_vc_sop),
        .rx_vc_eop   (rx_vc_eop),
        .rx_vc_empty (rx_vc_empty),
        .rx_vc_data  (rx_vc_data),
        .rx_vc_ready (rx_vc_ready)
`ifdef SONIC_RP_VC_STATS_EN
        ,
        .stat_tx_pkt    (stat_tx_pkt),
        .stat_rx_pkt    (stat_rx_pkt),
        .stat_proto_err (stat_proto_err)
`endif
    );

    typedef struct {
        logic [1:0] v, s, e;       // tx_vc valid/sop/eop
        logic [7:0] d0, d1;        // low byte of VC0/VC1 data
        logic       rdy;           // tx_st_ready
        logic       rxv, rxs, rxe; // rx_st valid/sop/eop
        logic [2:0] tc;            // TC in rx DW0
        logic [1:0] rxr;           // rx_vc_ready
        logic [1:0] e_vcr;         // expected tx_vc_ready
        logic       e_v, e_sop, e_eop;
        logic [7:0] e_tag;         // expected tx_st_data[7:0]
        logic [1:0] e_rxvcv;       // expected rx_vc_valid
        logic       e_rxr;         // expected rx_st_ready
    } vec_t;

    vec_t vecs [NV];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_tx_data(input logic [7:0] d0, input logic [7:0] d1);
        tx_vc_data              = '0;
        tx_vc_data[7:0]         = d0;
        tx_vc_data[DATA_W +: 8] = d1;
    endtask

    task automatic set_rx_data(input logic [2:0] tc);
        rx_st_data        = '0;
        rx_st_data[22:20] = tc;
        rx_st_data[7:0]   = 8'h5a;
    endtask

    task automatic drive_idle();
        tx_vc_valid = '0;
        tx_vc_sop   = '0;
        tx_vc_eop   = '0;
        tx_vc_empty = 2'b10;
        set_tx_data(8'h00, 8'h00);
        tx_st_ready = 1'b0;
        rx_st_valid = 1'b0;
        rx_st_sop   = 1'b0;
        rx_st_eop   = 1'b0;
        rx_st_empty = 1'b1;
        set_rx_data(3'd0);
        rx_vc_ready = '0;
    endtask

    // Waits (bounded) for vc_rstn to rise; returns at posedge+1
    task automatic wait_vc_rstn(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge pld_clk);
            #1;
            seen = vc_rstn;
        end
        check(name, {63'd0, vc_rstn}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // TX vectors: VC0 and VC1 3-beat packets, ready stalls, rr wrap, stray beat
        vecs[0]  = '{2'b11, 2'b11, 2'b00, 8'h01, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b01, 1'b1, 1'b1, 1'b0, 8'h01, 2'b00, 1'b0};
        vecs[1]  = '{2'b11, 2'b10, 2'b00, 8'h02, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b01, 1'b1, 1'b0, 1'b0, 8'h02, 2'b00, 1'b0};
        vecs[2]  = '{2'b11, 2'b10, 2'b01, 8'h03, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b00, 1'b1, 1'b0, 1'b1, 8'h03, 2'b00, 1'b0};
        vecs[3]  = '{2'b11, 2'b10, 2'b01, 8'h03, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b01, 1'b1, 1'b0, 1'b1, 8'h03, 2'b00, 1'b0};
        vecs[4]  = '{2'b10, 2'b10, 2'b00, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b00, 1'b1, 1'b1, 1'b0, 8'h11, 2'b00, 1'b0};
        vecs[5]  = '{2'b10, 2'b10, 2'b00, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b10, 1'b1, 1'b1, 1'b0, 8'h11, 2'b00, 1'b0};
        vecs[6]  = '{2'b11, 2'b01, 2'b00, 8'h21, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b10, 1'b1, 1'b0, 1'b0, 8'h12, 2'b00, 1'b0};
        vecs[7]  = '{2'b11, 2'b01, 2'b10, 8'h21, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b00, 1'b1, 1'b0, 1'b1, 8'h13, 2'b00, 1'b0};
        vecs[8]  = '{2'b11, 2'b01, 2'b10, 8'h21, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b10, 1'b1, 1'b0, 1'b1, 8'h13, 2'b00, 1'b0};
        vecs[9]  = '{2'b01, 2'b01, 2'b01, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b01, 1'b1, 1'b1, 1'b1, 8'h21, 2'b00, 1'b0};
        vecs[10] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0};
        vecs[11] = '{2'b11, 2'b11, 2'b11, 8'h31, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b10, 1'b1, 1'b1, 1'b1, 8'h41, 2'b00, 1'b0};
        vecs[12] = '{2'b01, 2'b01, 2'b01, 8'h31, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b01, 1'b1, 1'b1, 1'b1, 8'h31, 2'b00, 1'b0};
        vecs[13] = '{2'b01, 2'b00, 2'b00, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0};
        vecs[14] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0};
        // RX vectors: TC=3 packet to VC1 with a stall, then TC=6 single beat to VC0
        vecs[15] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 2'b11,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1};
        vecs[16] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'b01,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0};
        vecs[17] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'b11,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1};
        vecs[18] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 2'b10,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1};
        vecs[19] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 2'b01,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1};
        vecs[20] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 2'b10,
                     2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0};

        // Reset held with busy inputs: every valid/ready output must stay low
        drive_idle();
        tx_vc_valid = 2'b11;
        tx_vc_sop   = 2'b11;
        tx_st_ready = 1'b1;
        rx_st_valid = 1'b1;
        rx_st_sop   = 1'b1;
        rx_vc_ready = 2'b11;
        repeat (5) @(posedge pld_clk);
        @(negedge pld_clk);
        #1;
        check("rst vc_rstn",     {63'd0, vc_rstn},     64'd0);
        check("rst tx_st_valid", {63'd0, tx_st_valid}, 64'd0);
        check("rst tx_vc_ready", {62'd0, tx_vc_ready}, 64'd0);
        check("rst rx_vc_valid", {62'd0, rx_vc_valid}, 64'd0);
        check("rst rx_st_ready", {63'd0, rx_st_ready}, 64'd0);
        rstn = 1'b1;
        @(posedge pld_clk);
        #1;
        check("rst edge1 vc_rstn", {63'd0, vc_rstn}, 64'd0);
        @(posedge pld_clk);
        #1;
        check("rst edge2 vc_rstn", {63'd0, vc_rstn}, 64'd1);
        drive_idle();

        for (int i = 0; i < NV; i++) begin
            @(negedge pld_clk);
            tx_vc_valid = vecs[i].v;
            tx_vc_sop   = vecs[i].s;
            tx_vc_eop   = vecs[i].e;
            set_tx_data(vecs[i].d0, vecs[i].d1);
            tx_st_ready = vecs[i].rdy;
            rx_st_valid = vecs[i].rxv;
            rx_st_sop   = vecs[i].rxs;
            rx_st_eop   = vecs[i].rxe;
            set_rx_data(vecs[i].tc);
            rx_vc_ready = vecs[i].rxr;
            #1;
            check($sformatf("v%0d tx_vc_ready", i), {62'd0, tx_vc_ready}, {62'd0, vecs[i].e_vcr});
            check($sformatf("v%0d tx_st_valid", i), {63'd0, tx_st_valid}, {63'd0, vecs[i].e_v});
            if (vecs[i].e_v) begin
                check($sformatf("v%0d tx_st_sop", i), {63'd0, tx_st_sop}, {63'd0, vecs[i].e_sop});
                check($sformatf("v%0d tx_st_eop", i), {63'd0, tx_st_eop}, {63'd0, vecs[i].e_eop});
                check($sformatf("v%0d tx_st_data", i), {56'd0, tx_st_data[7:0]},
                      {56'd0, vecs[i].e_tag});
            end
            check($sformatf("v%0d rx_vc_valid", i), {62'd0, rx_vc_valid},
                  {62'd0, vecs[i].e_rxvcv});
            check($sformatf("v%0d rx_st_ready", i), {63'd0, rx_st_ready}, {63'd0, vecs[i].e_rxr});
            if (vecs[i].rxv) begin
                check($sformatf("v%0d rx_vc_tc", i), {61'd0, rx_vc_data[22:20]},
                      {61'd0, vecs[i].tc});
                check($sformatf("v%0d rx_vc_sop", i), {63'd0, rx_vc_sop}, {63'd0, vecs[i].rxs});
                check($sformatf("v%0d rx_vc_eop", i), {63'd0, rx_vc_eop}, {63'd0, vecs[i].rxe});
                check($sformatf("v%0d rx_vc_empty", i), {63'd0, rx_vc_empty}, 64'd1);
            end
        end

        // Reset in the middle of a 4-beat VC0 packet while VC1 waits with sop
        @(negedge pld_clk);
        drive_idle();
        tx_vc_valid = 2'b01;
        tx_vc_sop   = 2'b01;
        set_tx_data(8'ha0, 8'h00);
        tx_st_ready = 1'b1;
        #1;
        check("abort beat0 ready", {62'd0, tx_vc_ready}, 64'd1);
        @(negedge pld_clk);
        tx_vc_valid = 2'b11;
        tx_vc_sop   = 2'b10;
        set_tx_data(8'ha1, 8'hb0);
        #1;
        check("abort beat1 ready", {62'd0, tx_vc_ready}, 64'd1);
        check("abort beat1 data", {56'd0, tx_st_data[7:0]}, 64'ha1);
        @(negedge pld_clk);
        set_tx_data(8'ha2, 8'hb0);
        #1;
        check("abort beat2 valid", {63'd0, tx_st_valid}, 64'd1);
        rstn = 1'b0;
        #1;
        check("abort tx_st_valid", {63'd0, tx_st_valid}, 64'd0);
        check("abort tx_vc_ready", {62'd0, tx_vc_ready}, 64'd0);
        check("abort vc_rstn",     {63'd0, vc_rstn},     64'd0);
        repeat (2) @(posedge pld_clk);
        @(negedge pld_clk);
        rstn = 1'b1;
        wait_vc_rstn("abort release");
        check("abort vc1 ready", {62'd0, tx_vc_ready}, 64'd2);
        check("abort vc1 valid", {63'd0, tx_st_valid}, 64'd1);
        check("abort vc1 sop",   {63'd0, tx_st_sop},   64'd1);
        check("abort vc1 data",  {56'd0, tx_st_data[7:0]}, 64'hb0);
        check("abort vc1 empty", {63'd0, tx_st_empty}, 64'd1);

`ifdef SONIC_RP_VC_STATS_EN
        // Statistics: fresh reset, stray beat sets sticky error, 10 packets counted
        @(negedge pld_clk);
        rstn = 1'b0;
        drive_idle();
        repeat (2) @(negedge pld_clk);
        rstn = 1'b1;
        wait_vc_rstn("stats release");
        check("stats err clear", {63'd0, stat_proto_err}, 64'd0);
        check("stats tx clear",  {stat_tx_pkt}, 64'd0);
        @(negedge pld_clk);
        tx_vc_valid = 2'b01;
        @(negedge pld_clk);
        drive_idle();
        @(negedge pld_clk);
        #1;
        check("stats err sticky", {63'd0, stat_proto_err}, 64'd1);
        for (int p = 0; p < 10; p++) begin
            @(negedge pld_clk);
            tx_vc_valid = 2'b01;
            tx_vc_sop   = 2'b01;
            tx_vc_eop   = 2'b01;
            tx_st_ready = 1'b1;
        end
        @(negedge pld_clk);
        drive_idle();
        #1;
        check("stats tx vc0", {32'd0, stat_tx_pkt[31:0]},  64'd10);
        check("stats tx vc1", {32'd0, stat_tx_pkt[63:32]}, 64'd0);
        check("stats rx",     {stat_rx_pkt}, 64'd0);
        check("stats err hold", {63'd0, stat_proto_err}, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
